regbank_access_ctrl: RTL and testbench
======================================

// Module: regbank_access_ctrl
// PURPOSE
//  Sequencer and arbiter for a bank of NREG registers, each W dffdm-style bits sharing rd, rd_latch, data-in bus.
//  Two requesters (A = core datapath, B = user/debug) issue single read or write transactions.
//  Controller grants one at a time, drives one-hot sel plus the rd/rd_latch/write protocol, captures read data.
//  Sits between the core/user ports and the register bank.
// PARAMETERS
//  NREG  8  number of registers in the bank (1..2**AW)
//  AW    3  address width
//  W     8  register data width
// PORTS
//  clk       in   1     system clock, rising edge
//  clr       in   1     reset, asynchronous, active-low
//  a_req     in   1     A transaction request; held until a_ack
//  a_we      in   1     A: 1 = write, 0 = read
//  a_addr    in   AW    A register address
//  a_wdata   in   W     A write data
//  a_ack     out  1     A completion, 1-cycle pulse
//  a_rdata   out  W     A read data, valid with a_ack, held until next A read completes
//  b_*       -    -     identical set for requester B (b_req, b_we, b_addr, b_wdata, b_ack, b_rdata)
//  sel       out  NREG  one-hot register select to bank
//  rd        out  1     bank read enable
//  rd_latch  out  1     bank read-latch enable
//  wr_stb    out  1     bank write strobe, 1 cycle
//  wdata     out  W     data to bank d_in bus
//  rbus      in   W     bank visible-output bus (q_vis)
//  busy      out  1     1 whenever FSM not IDLE
//  owner_b   out  1     1 = current/last grant belongs to B
// BEHAVIOUR
//  Reset (clr low, async): FSM=IDLE; every output 0; last-grant = B, so A wins first tie.
//  Arbitration in IDLE only, at rising edge:
//   - only one req high -> grant it
//   - both high -> grant the port NOT granted last (round robin)
//   - latch addr, we, wdata of granted port; later changes on inputs ignored
//  Read FSM, one cycle per state:
//   IDLE -> R_SEL -> R_RD -> R_LAT -> R_HOLD -> R_REL1 -> R_REL2 -> R_REL3 -> IDLE
//   - sel=onehot(addr) in all R_* states
//   - rd=1 in R_RD..R_REL1
//   - rd_latch=1 in R_LAT, R_REL1, R_REL2
//   - rdata captured from rbus at edge leaving R_HOLD
//   - ack high during R_REL3
//   - read latency: req sampled at edge 0 -> ack in cycle 7
//  Write FSM:
//   IDLE -> W_SEL -> W_STB -> W_DONE -> IDLE
//   - sel valid and wdata driven in all W_* states
//   - wr_stb=1 in W_STB only; ack high in W_DONE (cycle 3)
//  Requester handshake:
//   - req must be low in cycle after ack; req still high when FSM reaches IDLE = new request
//   - req dropped before ack: transaction still completes and acks
//  Bank outputs:
//   - rd, rd_latch, wr_stb, sel all 0 in IDLE
//   - wdata holds last written value
//   - sel never changes while rd or rd_latch high
//  Out-of-range addr (>= NREG): full state sequence and ack timing unchanged
//   - sel all-zero; read returns 0; write no effect
//  a_ack and b_ack never high together; each pulse is exactly 1 cycle.
//  Reset mid-transaction: FSM to IDLE immediately; all bank controls drop; no ack issued; rdata cleared to 0.
// TESTING
//  1. Reset: clr low mid-sim -> all outputs 0, busy=0; release -> idle, no ack.
//  2. A read addr 3, rbus=8'hA5 -> sel=8'h08; rd/rd_latch/ack pattern as above.
//     Check: a_ack in cycle 7, a_rdata=8'hA5, b_ack stays 0.
//  3. B write addr 5, data 8'h3C -> wdata=8'h3C, sel=8'h20, wr_stb 1 cycle (cycle 2), b_ack in cycle 3.
//  4. A and B req same edge after reset, A reads then B writes.
//     Check: A served first, B granted on the IDLE edge after a_ack, owner_b toggles.
//     Continuous requests alternate A,B,A,B.
//  5. NREG=6, A read addr 7 -> sel=0, a_rdata=0, ack in cycle 7; write to 6 -> no wr effect on sel, ack in cycle 3.
//  6. clr pulsed low during R_LAT -> rd, rd_latch, sel drop at once, no a_ack.
//     Check: re-issued read completes normally with correct data.

Source files
------------

// File: rtl/regbank_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | regbank_access_ctrl: two-port arbiter and rd/rd_latch/write sequencer     |
// |                      for a shared register bank. Rev 1.0                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module regbank_access_ctrl #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int W    = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [AW-1:0]   a_addr,
  input  logic [W-1:0]    a_wdata,
  output logic            a_ack,
  output logic [W-1:0]    a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [AW-1:0]   b_addr,
  input  logic [W-1:0]    b_wdata,
  output logic            b_ack,
  output logic [W-1:0]    b_rdata,
  output logic [NREG-1:0] sel,
  output logic            rd,
  output logic            rd_latch,
  output logic            wr_stb,
  output logic [W-1:0]    wdata,
  input  logic [W-1:0]    rbus,
  output logic            busy,
  output logic            owner_b
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_R_SEL  = 4'd1,
    S_R_RD   = 4'd2,
    S_R_LAT  = 4'd3,
    S_R_HOLD = 4'd4,
    S_R_REL1 = 4'd5,
    S_R_REL2 = 4'd6,
    S_R_REL3 = 4'd7,
    S_W_SEL  = 4'd8,
    S_W_STB  = 4'd9,
    S_W_DONE = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            last_b_q, last_b_d;
  logic            owner_b_q, owner_b_d;
  logic [W-1:0]    wdata_q, wdata_d;
  logic [W-1:0]    rbuf_q, rbuf_d;
  logic [W-1:0]    a_rdata_q, a_rdata_d;
  logic [W-1:0]    b_rdata_q, b_rdata_d;
  logic [NREG-1:0] sel_q, sel_d;
  logic            rd_q, rd_d;
  logic            rd_latch_q, rd_latch_d;
  logic            wr_stb_q, wr_stb_d;
  logic            a_ack_q, a_ack_d;
  logic            b_ack_q, b_ack_d;
  logic            busy_q, busy_d;

  logic            gnt_a, gnt_b, gnt_we;
  logic [AW-1:0]   gnt_addr;
  logic [W-1:0]    gnt_wdata;
  logic            done;

  // Out-of-range addresses decode to an all-zero select.
  function automatic logic [NREG-1:0] onehot(input logic [AW-1:0] a);
    logic [NREG-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++) begin
      if (a == AW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_b_d   = last_b_q;
    owner_b_d  = owner_b_q;
    wdata_d    = wdata_q;
    rbuf_d     = rbuf_q;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;

    // Round robin: on a tie the port not granted last wins.
    gnt_a      = a_req & (~b_req | last_b_q);
    gnt_b      = b_req & (~a_req | ~last_b_q);
    gnt_we     = gnt_b ? b_we : a_we;
    gnt_addr   = gnt_b ? b_addr : a_addr;
    gnt_wdata  = gnt_b ? b_wdata : a_wdata;

    case (state_q)
      S_IDLE: begin
        if (gnt_a || gnt_b) begin
          state_d   = gnt_we ? S_W_SEL : S_R_SEL;
          addr_d    = gnt_addr;
          last_b_d  = gnt_b;
          owner_b_d = gnt_b;
          if (gnt_we) wdata_d = gnt_wdata;
        end
      end
      S_R_SEL:  state_d = S_R_RD;
      S_R_RD:   state_d = S_R_LAT;
      S_R_LAT:  state_d = S_R_HOLD;
      S_R_HOLD: begin
        state_d = S_R_REL1;
        rbuf_d  = (|sel_q) ? rbus : '0;
      end
      S_R_REL1: state_d = S_R_REL2;
      S_R_REL2: state_d = S_R_REL3;
      S_R_REL3: state_d = S_IDLE;
      S_W_SEL:  state_d = S_W_STB;
      S_W_STB:  state_d = S_W_DONE;
      S_W_DONE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    sel_d      = (state_d != S_IDLE) ? onehot(addr_d) : '0;
    rd_d       = (state_d == S_R_RD) || (state_d == S_R_LAT) ||
                 (state_d == S_R_HOLD) || (state_d == S_R_REL1);
    rd_latch_d = (state_d == S_R_LAT) || (state_d == S_R_REL1) ||
                 (state_d == S_R_REL2);
    wr_stb_d   = (state_d == S_W_STB);
    busy_d     = (state_d != S_IDLE);
    done       = (state_d == S_R_REL3) || (state_d == S_W_DONE);
    a_ack_d    = done & ~owner_b_d;
    b_ack_d    = done & owner_b_d;

    // Read data reaches the port only with the ack, so it holds until then.
    if (state_d == S_R_REL3) begin
      if (owner_b_d) b_rdata_d = rbuf_q;
      else           a_rdata_d = rbuf_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_b_q   <= 1'b1;
      owner_b_q  <= 1'b0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      sel_q      <= '0;
      rd_q       <= 1'b0;
      rd_latch_q <= 1'b0;
      wr_stb_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_b_q   <= last_b_d;
      owner_b_q  <= owner_b_d;
      wdata_q    <= wdata_d;
      rbuf_q     <= rbuf_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
      sel_q      <= sel_d;
      rd_q       <= rd_d;
      rd_latch_q <= rd_latch_d;
      wr_stb_q   <= wr_stb_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      busy_q     <= busy_d;
    end
  end

  assign sel      = sel_q;
  assign rd       = rd_q;
  assign rd_latch = rd_latch_q;
  assign wr_stb   = wr_stb_q;
  assign wdata    = wdata_q;
  assign a_ack    = a_ack_q;
  assign b_ack    = b_ack_q;
  assign a_rdata  = a_rdata_q;
  assign b_rdata  = b_rdata_q;
  assign busy     = busy_q;
  assign owner_b  = owner_b_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_access_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_regbank_access_ctrl: directed vector bench, NREG=6 bank. Rev 1.0       |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regbank_access_ctrl;

  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int W    = 8;

  logic            clk = 1'b0;
  logic            clr = 1'b0;
  logic            a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0]   a_addr = '0, b_addr = '0;
  logic [W-1:0]    a_wdata = '0, b_wdata = '0, rbus = '0;
  logic            a_ack, b_ack, rd, rd_latch, wr_stb, busy, owner_b;
  logic [W-1:0]    a_rdata, b_rdata, wdata;
  logic [NREG-1:0] sel;

  int n_vec  = 0;
  int n_fail = 0;
  logic [W-1:0] mdl_a_rdata = '0;
  logic [W-1:0] mdl_b_rdata = '0;

  regbank_access_ctrl #(.NREG(NREG), .AW(AW), .W(W)) u_dut (
    .clk(clk), .clr(clr),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .sel(sel), .rd(rd), .rd_latch(rd_latch), .wr_stb(wr_stb),
    .wdata(wdata), .rbus(rbus), .busy(busy), .owner_b(owner_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            port_b;
    logic            we;
    logic [AW-1:0]   addr;
    logic [W-1:0]    data;
    logic [W-1:0]    rbus_v;
    logic [NREG-1:0] exp_sel;
    logic [W-1:0]    exp_rdata;
    logic            early;
  } txn_t;

  txn_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " sel"}, 32'(sel), 0);
    chk({tag, " rd"}, 32'(rd), 0);
    chk({tag, " rd_latch"}, 32'(rd_latch), 0);
    chk({tag, " wr_stb"}, 32'(wr_stb), 0);
    chk({tag, " wdata"}, 32'(wdata), 0);
    chk({tag, " a_ack"}, 32'(a_ack), 0);
    chk({tag, " b_ack"}, 32'(b_ack), 0);
    chk({tag, " a_rdata"}, 32'(a_rdata), 0);
    chk({tag, " b_rdata"}, 32'(b_rdata), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " owner_b"}, 32'(owner_b), 0);
  endtask

  // Issue one transaction at a negedge, check every cycle through the idle cycle after ack.
  task automatic do_txn(input txn_t t, input int idx);
    int   n;
    logic ctl, e_rd, e_lat, e_stb, e_ack;
    string tg;
    n   = t.we ? 3 : 7;
    ctl = (t.exp_sel != '0);
    rbus = t.rbus_v;
    if (t.port_b) begin
      b_req = 1'b1; b_we = t.we; b_addr = t.addr; b_wdata = t.data;
    end else begin
      a_req = 1'b1; a_we = t.we; a_addr = t.addr; a_wdata = t.data;
    end
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      tg    = $sformatf("txn%0d c%0d", idx, c);
      e_rd  = !t.we && (c >= 2) && (c <= 5);
      e_lat = !t.we && ((c == 3) || (c == 5) || (c == 6));
      e_stb = t.we && (c == 2);
      e_ack = (c == n);
      if (t.early && c == 1) begin
        a_req = 1'b0; b_req = 1'b0;
        a_addr = '1; b_addr = '1; a_wdata = '0; b_wdata = '0;
      end
      chk({tg, " sel"}, 32'(sel), 32'(t.exp_sel));
      chk({tg, " busy"}, 32'(busy), 1);
      chk({tg, " owner_b"}, 32'(owner_b), 32'(t.port_b));
      chk({tg, " a_ack"}, 32'(a_ack), 32'(e_ack && !t.port_b));
      chk({tg, " b_ack"}, 32'(b_ack), 32'(e_ack && t.port_b));
      if (ctl) begin
        chk({tg, " rd"}, 32'(rd), 32'(e_rd));
        chk({tg, " rd_latch"}, 32'(rd_latch), 32'(e_lat));
        chk({tg, " wr_stb"}, 32'(wr_stb), 32'(e_stb));
        if (t.we) chk({tg, " wdata"}, 32'(wdata), 32'(t.data));
      end
      if (!t.we && c == 6) begin
        chk({tg, " a_rdata held"}, 32'(a_rdata), 32'(mdl_a_rdata));
        chk({tg, " b_rdata held"}, 32'(b_rdata), 32'(mdl_b_rdata));
      end
      if (e_ack) begin
        a_req = 1'b0; b_req = 1'b0;
        if (!t.we) begin
          if (t.port_b) mdl_b_rdata = t.exp_rdata;
          else          mdl_a_rdata = t.exp_rdata;
        end
        chk({tg, " a_rdata"}, 32'(a_rdata), 32'(mdl_a_rdata));
        chk({tg, " b_rdata"}, 32'(b_rdata), 32'(mdl_b_rdata));
      end
    end
    @(negedge clk);
    tg = $sformatf("txn%0d idle", idx);
    chk({tg, " busy"}, 32'(busy), 0);
    chk({tg, " sel"}, 32'(sel), 0);
    chk({tg, " rd"}, 32'(rd), 0);
    chk({tg, " acks"}, 32'({a_ack, b_ack}), 0);
    if (t.we && ctl) chk({tg, " wdata hold"}, 32'(wdata), 32'(t.data));
  endtask

  int          k;
  int          ack_cyc[4];
  logic        ack_port[4];
  int          exp_cyc[4];
  logic        exp_port[4];

  initial begin
    //            port we addr  data   rbus   sel      rdata  early
    tbl[0] = '{1'b0, 1'b0, 3'd3, 8'h00, 8'hA5, 6'h08, 8'hA5, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 3'd5, 8'h3C, 8'h00, 6'h20, 8'h00, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h5A, 6'h01, 8'h5A, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 3'd4, 8'h00, 8'h99, 6'h10, 8'h99, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 3'd2, 8'hE7, 8'h00, 6'h04, 8'h00, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 3'd7, 8'h00, 8'hFF, 6'h00, 8'h00, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 3'd6, 8'h81, 8'h00, 6'h00, 8'h00, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 3'd1, 8'h00, 8'hC3, 6'h02, 8'hC3, 1'b0};
    exp_cyc  = '{7, 11, 19, 23};
    exp_port = '{1'b0, 1'b1, 1'b0, 1'b1};

    // Power-on reset
    repeat (2) @(negedge clk);
    chk_outputs_zero("por");
    clr = 1'b1;
    @(negedge clk);
    chk_outputs_zero("por released");

    foreach (tbl[i]) do_txn(tbl[i], i);

    // Plain reset mid-simulation clears everything, including held wdata/rdata
    clr = 1'b0;
    #1;
    chk_outputs_zero("mid reset");
    mdl_a_rdata = '0; mdl_b_rdata = '0;
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("post reset c%0d busy/acks", c), 32'({busy, a_ack, b_ack}), 0);
    end

    // Simultaneous requests after reset: A read, B write, continuously re-requested
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    rbus = 8'h42;
    a_we = 1'b0; a_addr = 3'd3; a_req = 1'b1;
    b_we = 1'b1; b_addr = 3'd4; b_wdata = 8'h5C; b_req = 1'b1;
    k = 0;
    for (int cyc = 1; cyc <= 60 && k < 4; cyc++) begin
      @(negedge clk);
      chk($sformatf("rr c%0d acks exclusive", cyc), 32'(a_ack && b_ack), 0);
      if (a_ack || b_ack) begin
        ack_cyc[k]  = cyc;
        ack_port[k] = b_ack;
        chk($sformatf("rr ack%0d owner_b", k), 32'(owner_b), 32'(b_ack));
        if (a_ack) chk($sformatf("rr ack%0d a_rdata", k), 32'(a_rdata), 32'h42);
        else       chk($sformatf("rr ack%0d wdata", k), 32'(wdata), 32'h5C);
        if (b_ack) chk($sformatf("rr ack%0d b sel", k), 32'(sel), 32'h10);
        k++;
      end
      a_req = (k < 4) && !a_ack;
      b_req = (k < 4) && !b_ack;
    end
    a_req = 1'b0; b_req = 1'b0;
    chk("rr ack count", 32'(k), 4);
    for (int i = 0; i < 4 && i < k; i++) begin
      chk($sformatf("rr ack%0d cycle", i), 32'(ack_cyc[i]), 32'(exp_cyc[i]));
      chk($sformatf("rr ack%0d port", i), 32'(ack_port[i]), 32'(exp_port[i]));
    end
    @(negedge clk);
    chk("rr drained busy", 32'(busy), 0);
    mdl_a_rdata = 8'h42; mdl_b_rdata = '0;

    // Reset pulsed during R_LAT: controls drop immediately, no ack, rdata cleared
    rbus = 8'h77;
    a_we = 1'b0; a_addr = 3'd2; a_req = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("rlat rd", 32'(rd), 1);
    chk("rlat rd_latch", 32'(rd_latch), 1);
    chk("rlat sel", 32'(sel), 32'h04);
    a_req = 1'b0;
    #2 clr = 1'b0;
    #1;
    chk("rlat reset rd", 32'(rd), 0);
    chk("rlat reset rd_latch", 32'(rd_latch), 0);
    chk("rlat reset sel", 32'(sel), 0);
    chk("rlat reset busy", 32'(busy), 0);
    chk("rlat reset a_rdata", 32'(a_rdata), 0);
    mdl_a_rdata = '0;
    @(negedge clk);
    clr = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk($sformatf("rlat after c%0d a_ack", c), 32'(a_ack), 0);
    end
    do_txn('{1'b0, 1'b0, 3'd2, 8'h00, 8'h77, 6'h04, 8'h77, 1'b0}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
